// File: rtl/demo_rsp_pkg.sv
// -----------------------------------------------------------------------------
// demo_rsp_pkg
//   Shared definitions for the response collector: FSM state encoding, result
//   code width and the legal result code range, plus a helper that classifies
//   a result code.
// -----------------------------------------------------------------------------
package demo_rsp_pkg;

  localparam int RESULT_W   = 4;
  localparam int RESULT_MIN = 1;
  localparam int RESULT_MAX = 10;

  // Collector FSM states. Exposed on the top-level debug output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // A result code is legal when it lies inside RESULT_MIN..RESULT_MAX.
  function automatic logic is_legal(input logic [RESULT_W-1:0] result);
    return (int'(result) >= RESULT_MIN) && (int'(result) <= RESULT_MAX);
  endfunction

endpackage

// File: rtl/demo_rsp_fifo.sv
// -----------------------------------------------------------------------------
// demo_rsp_fifo
//   Parameterized show-ahead synchronous FIFO. The head entry is visible on
//   rdata_o whenever the FIFO is not empty (zero-latency read); rdata_o is
//   forced to zero while empty. A pushed entry becomes visible one cycle after
//   the push. flush_i empties the FIFO and overrides push and pop.
//
//   Ports
//     clk, rst_n   : clock (rising edge), asynchronous active-low reset
//     flush_i      : synchronous flush (pointers and count to zero)
//     push_i       : write wdata_i (ignored when full unless pop_i is set)
//     wdata_i      : entry to write
//     pop_i        : remove head entry (ignored when empty)
//     rdata_o      : head entry, zero when empty
//     full_o       : count == DEPTH
//     empty_o      : count == 0
//     count_o      : occupancy, 0..DEPTH
//
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module demo_rsp_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the
  // read data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/demo_rsp_collect.sv
// -----------------------------------------------------------------------------
// demo_rsp_collect
//   Collects result beats from an upstream source that cannot be stalled.
//   Legal beats (result code 1..10) are buffered in a show-ahead FIFO and
//   offered downstream over a valid/ready pair. A burst closes once
//   EXPECT_CNT legal beats have been accepted; afterwards every beat is
//   ignored until clr_i or reset. Illegal beats raise a sticky err flag;
//   legal beats that find the FIFO full are dropped and counted in ovf_cnt.
//
//   Handshake: out_vld is high whenever the FIFO holds an entry; the head is
//   consumed on a rising clk edge where out_vld and out_rdy are both high, and
//   the payload stays stable while out_vld=1 and out_rdy=0.
//
//   Ports
//     clk, rst_n        : clock (rising edge), asynchronous active-low reset
//     vld_i, result_i   : upstream beat valid and result code
//     addr_i, data_i    : upstream beat payload
//     clr_i             : synchronous clear (flush, zero counters, go IDLE)
//     out_vld, out_rdy  : downstream valid/ready
//     out_result/addr/data : FIFO head, zero when empty
//     full, empty, count: FIFO occupancy
//     acc_cnt, ovf_cnt  : accepted legal beats / legal beats dropped on full
//     err, done         : sticky illegal-code flag / burst complete
//     dbg_state_o       : current FSM state
// -----------------------------------------------------------------------------
module demo_rsp_collect
  import demo_rsp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int EXPECT_CNT = 10,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [RESULT_W-1:0]   result_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clr_i,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [RESULT_W-1:0]   out_result,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [7:0]            acc_cnt,
  output logic [7:0]            ovf_cnt,
  output logic                  err,
  output logic                  done,
  output state_e                dbg_state_o
);

  localparam int ENTRY_W = RESULT_W + ADDR_WIDTH + DATA_WIDTH;

  state_e     state_q, state_d;
  logic [7:0] acc_cnt_q, acc_cnt_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic       err_q, err_d;

  logic               beat_legal;
  logic               beat_illegal;
  logic               live;
  logic               pop;
  logic               push;
  logic               drop_ovf;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign beat_legal   = vld_i && is_legal(result_i);
  assign beat_illegal = vld_i && !is_legal(result_i);

  // Beats are only considered outside DONE and never in a clearing cycle.
  assign live = (state_q != ST_DONE) && !clr_i;

  assign out_vld  = !empty;
  assign pop      = out_vld && out_rdy;
  assign push     = live && beat_legal && (!full || pop);
  assign drop_ovf = live && beat_legal && full && !pop;

  assign fifo_wdata = {result_i, addr_i, data_i};

  demo_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clr_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign {out_result, out_addr, out_data} = fifo_rdata;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    err_d     = err_q;
    if (clr_i) begin
      state_d   = ST_IDLE;
      acc_cnt_d = '0;
      ovf_cnt_d = '0;
      err_d     = 1'b0;
    end else begin
      if (push) acc_cnt_d = acc_cnt_q + 8'd1;
      if (drop_ovf && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
      if (live && beat_illegal) err_d = 1'b1;

      if ((state_q == ST_IDLE) && live && beat_legal) state_d = ST_ACTIVE;
      // Reaching the burst length wins over IDLE->ACTIVE, so EXPECT_CNT=1
      // goes straight from IDLE to DONE.
      if (push && ((acc_cnt_q + 8'd1) == 8'(EXPECT_CNT))) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      ovf_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      err_q     <= err_d;
    end
  end

  assign acc_cnt     = acc_cnt_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign err         = err_q;
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_demo_rsp_collect.sv
// -----------------------------------------------------------------------------
// tb_demo_rsp_collect
//   Self-checking bench for demo_rsp_collect. A queue-based behavioural model
//   tracks the expected FIFO contents, counters, flags and burst state; one
//   compare process checks every DUT output against it on each falling edge.
//   Directed scenarios add hand-computed literal checks, followed by a
//   randomized run.
// -----------------------------------------------------------------------------
module tb_demo_rsp_collect;
  import demo_rsp_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int EXP   = 10;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = RESULT_W + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic                vld_i;
  logic [RESULT_W-1:0] result_i;
  logic [AW-1:0]       addr_i;
  logic [DW-1:0]       data_i;
  logic                clr_i;
  logic                out_vld;
  logic                out_rdy;
  logic [RESULT_W-1:0] out_result;
  logic [AW-1:0]       out_addr;
  logic [DW-1:0]       out_data;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic [7:0]          acc_cnt;
  logic [7:0]          ovf_cnt;
  logic                err;
  logic                done;
  state_e              dbg_state;

  demo_rsp_collect #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .EXPECT_CNT (EXP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld_i       (vld_i),
    .result_i    (result_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .clr_i       (clr_i),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_result  (out_result),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .acc_cnt     (acc_cnt),
    .ovf_cnt     (ovf_cnt),
    .err         (err),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [EW-1:0] exp_q[$];
  int            m_acc;
  int            m_ovf;
  bit            m_err;
  state_e        m_st;
  bit            m_pop;
  bit            m_room;
  bit            m_legal;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0;
      m_ovf = 0;
      m_err = 1'b0;
      m_st  = ST_IDLE;
    end else begin
      m_pop   = (exp_q.size() > 0) && out_rdy;
      m_room  = (exp_q.size() < DEPTH) || m_pop;
      m_legal = vld_i && (result_i >= 4'd1) && (result_i <= 4'd10);
      if (clr_i) begin
        exp_q.delete();
        m_acc = 0;
        m_ovf = 0;
        m_err = 1'b0;
        m_st  = ST_IDLE;
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_st != ST_DONE && vld_i) begin
          if (!m_legal) begin
            m_err = 1'b1;
          end else if (m_room) begin
            exp_q.push_back({result_i, addr_i, data_i});
            m_acc++;
            if (m_st == ST_IDLE) m_st = ST_ACTIVE;
            if (m_acc == EXP) m_st = ST_DONE;
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [EW-1:0] m_head;

  always @(negedge clk) begin
    if (rst_n) begin
      m_head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("out_vld",    32'(out_vld),    32'(exp_q.size() > 0));
      check("out_result", 32'(out_result), 32'(m_head[EW-1 -: RESULT_W]));
      check("out_addr",   32'(out_addr),   32'(m_head[DW +: AW]));
      check("out_data",   32'(out_data),   32'(m_head[DW-1:0]));
      check("full",       32'(full),       32'(exp_q.size() == DEPTH));
      check("empty",      32'(empty),      32'(exp_q.size() == 0));
      check("count",      32'(count),      32'(exp_q.size()));
      check("acc_cnt",    32'(acc_cnt),    32'(m_acc));
      check("ovf_cnt",    32'(ovf_cnt),    32'(m_ovf));
      check("err",        32'(err),        32'(m_err));
      check("done",       32'(done),       32'(m_st == ST_DONE));
      check("state",      32'(dbg_state),  32'(m_st));
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs just after a rising edge, waits for the next
  // rising edge, and returns 1 time unit after it.
  task automatic drive(input bit v, input logic [RESULT_W-1:0] r, input bit rdy, input bit clr);
    vld_i    = v;
    result_i = r;
    addr_i   = AW'($urandom);
    data_i   = DW'($urandom);
    out_rdy  = rdy;
    clr_i    = clr;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    clr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    vld_i    = 1'b0;
    result_i = '0;
    addr_i   = '0;
    data_i   = '0;
    clr_i    = 1'b0;
    out_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty),   32'd1);
    check("rst_vld",   32'(out_vld), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Burst of 10 legal beats, results 1..10, downstream always ready.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, RESULT_W'(i), 1'b1, 1'b0);
      if (i == 9) check("s1_not_done_at_9", 32'(done), 32'd0);
    end
    check("s1_done",  32'(done),    32'd1);
    check("s1_acc",   32'(acc_cnt), 32'd10);
    check("s1_ovf",   32'(ovf_cnt), 32'd0);
    check("s1_count", 32'(count),   32'd1);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    check("s1_drained", 32'(empty), 32'd1);
    drive(1'b1, 4'd3, 1'b1, 1'b0);
    check("s1_done_drop_acc",   32'(acc_cnt), 32'd10);
    check("s1_done_drop_empty", 32'(empty),   32'd1);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("s1_clr_done", 32'(done),    32'd0);
    check("s1_clr_acc",  32'(acc_cnt), 32'd0);

    // Overflow with downstream stalled, then push+pop on a full FIFO.
    for (int i = 0; i < 6; i++) drive(1'b1, RESULT_W'(1 + i), 1'b0, 1'b0);
    check("s2_full",  32'(full),    32'd1);
    check("s2_count", 32'(count),   32'd4);
    check("s2_ovf",   32'(ovf_cnt), 32'd2);
    check("s2_acc",   32'(acc_cnt), 32'd4);
    check("s2_head",  32'(out_result), 32'd1);
    drive(1'b1, 4'd7, 1'b1, 1'b0);
    check("s3_count", 32'(count),   32'd4);
    check("s3_ovf",   32'(ovf_cnt), 32'd2);
    check("s3_acc",   32'(acc_cnt), 32'd5);
    check("s3_head",  32'(out_result), 32'd2);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    check("s3_drained", 32'(empty), 32'd1);

    // Illegal codes in ACTIVE: sticky err, beat dropped.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    drive(1'b1, 4'd12, 1'b1, 1'b0);
    check("s4_err", 32'(err),     32'd1);
    check("s4_acc", 32'(acc_cnt), 32'd1);
    drive(1'b1, 4'd0, 1'b1, 1'b0);
    check("s4_zero_acc", 32'(acc_cnt), 32'd1);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    check("s4_err_sticky", 32'(err), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("s4_err_clr", 32'(err), 32'd0);

    // Clear with 3 entries queued and a legal beat in the same cycle.
    repeat (3) drive(1'b1, 4'd2, 1'b0, 1'b0);
    check("s5_count", 32'(count), 32'd3);
    drive(1'b1, 4'd4, 1'b0, 1'b1);
    check("s5_empty", 32'(empty),     32'd1);
    check("s5_acc",   32'(acc_cnt),   32'd0);
    check("s5_state", 32'(dbg_state), 32'(ST_IDLE));
    drive(1'b0, '0, 1'b0, 1'b0);
    check("s5_beat_lost", 32'(empty), 32'd1);

    // Asynchronous reset mid-cycle in ACTIVE with 2 entries queued.
    repeat (2) drive(1'b1, 4'd3, 1'b0, 1'b0);
    drive(1'b1, 4'd15, 1'b0, 1'b0);
    check("s6_count", 32'(count),     32'd2);
    check("s6_state", 32'(dbg_state), 32'(ST_ACTIVE));
    check("s6_err",   32'(err),       32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_vld",   32'(out_vld),    32'd0);
    check("s6_rst_empty", 32'(empty),      32'd1);
    check("s6_rst_full",  32'(full),       32'd0);
    check("s6_rst_count", 32'(count),      32'd0);
    check("s6_rst_res",   32'(out_result), 32'd0);
    check("s6_rst_data",  32'(out_data),   32'd0);
    check("s6_rst_acc",   32'(acc_cnt),    32'd0);
    check("s6_rst_err",   32'(err),        32'd0);
    check("s6_rst_done",  32'(done),       32'd0);
    check("s6_rst_state", 32'(dbg_state),  32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      logic [RESULT_W-1:0] r;
      r = ($urandom_range(0, 9) < 8) ? RESULT_W'($urandom_range(1, 10))
                                     : RESULT_W'($urandom_range(0, 15));
      drive($urandom_range(0, 9) < 7, r, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
